// File: rtl/operand_bypass_if.sv
// Operand bypass bus: forwarder select codes, register-file data, commit/load-return
// events in; final EX operands and load hazard status out.
interface operand_bypass_if #(
  parameter int XLEN = 32
);
  logic [1:0]      rs1_sel;
  logic [1:0]      rs2_sel;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic            res_valid;
  logic            res_is_load;
  logic [XLEN-1:0] res_data;
  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            stall_in;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            load_use_stall;
  logic            load_err;

  modport master (
    output rs1_sel, rs2_sel, rf_rs1_data, rf_rs2_data,
    output res_valid, res_is_load, res_data, load_valid, load_data, stall_in,
    input  rs1_fwd, rs2_fwd, load_use_stall, load_err
  );

  modport slave (
    input  rs1_sel, rs2_sel, rf_rs1_data, rf_rs2_data,
    input  res_valid, res_is_load, res_data, load_valid, load_data, stall_in,
    output rs1_fwd, rs2_fwd, load_use_stall, load_err
  );
endinterface

// File: rtl/operand_bypass_unit.sv
// Two-deep write-result history (A newest, B older) feeding the EX operand mux,
// with pending-load tracking, same-cycle load bypass and load-use stall.
module operand_bypass_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  operand_bypass_if.slave bus
);

  logic [XLEN-1:0] a_data_reg, a_data_next;
  logic            a_pend_reg, a_pend_next;
  logic [XLEN-1:0] b_data_reg, b_data_next;
  logic            b_pend_reg, b_pend_next;
  logic            load_err_reg, load_err_next;

  logic            fill_a, fill_b, orphan_load, shift;
  logic [XLEN-1:0] a_data_filled, b_data_filled;
  logic            a_pend_filled, b_pend_filled;

  // Returning load data always resolves the oldest outstanding load first.
  assign fill_b      = bus.load_valid & b_pend_reg;
  assign fill_a      = bus.load_valid & ~b_pend_reg & a_pend_reg;
  assign orphan_load = bus.load_valid & ~b_pend_reg & ~a_pend_reg;
  assign shift       = bus.res_valid & ~bus.stall_in;

  assign a_data_filled = fill_a ? bus.load_data : a_data_reg;
  assign a_pend_filled = a_pend_reg & ~fill_a;
  assign b_data_filled = fill_b ? bus.load_data : b_data_reg;
  assign b_pend_filled = b_pend_reg & ~fill_b;

  // Fill is applied before the shift, so a filled A migrates into B resolved.
  always_comb begin
    a_data_next   = a_data_filled;
    a_pend_next   = a_pend_filled;
    b_data_next   = b_data_filled;
    b_pend_next   = b_pend_filled;
    load_err_next = load_err_reg | orphan_load;
    if (shift) begin
      b_data_next = a_data_filled;
      b_pend_next = a_pend_filled;
      if (bus.res_is_load) begin
        a_data_next = '0;
        a_pend_next = 1'b1;
      end else begin
        a_data_next = bus.res_data;
        a_pend_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_reg   <= '0;
      a_pend_reg   <= 1'b0;
      b_data_reg   <= '0;
      b_pend_reg   <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      a_data_reg   <= a_data_next;
      a_pend_reg   <= a_pend_next;
      b_data_reg   <= b_data_next;
      b_pend_reg   <= b_pend_next;
      load_err_reg <= load_err_next;
    end
  end

  logic [1:0]      sel_arr [2];
  logic [XLEN-1:0] rf_arr  [2];
  logic [XLEN-1:0] fwd_arr [2];
  logic [1:0]      stall_vec;

  assign sel_arr[0] = bus.rs1_sel;
  assign sel_arr[1] = bus.rs2_sel;
  assign rf_arr[0]  = bus.rf_rs1_data;
  assign rf_arr[1]  = bus.rf_rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic            hit_a, hit_b;
    logic [XLEN-1:0] a_view, b_view;

    assign hit_a  = (sel_arr[gi] == 2'd1);
    assign hit_b  = (sel_arr[gi] == 2'd2);
    // A slot being filled this cycle is seen through to the returning data.
    assign a_view = fill_a ? bus.load_data : a_data_reg;
    assign b_view = fill_b ? bus.load_data : b_data_reg;

    assign fwd_arr[gi]   = hit_a ? a_view : (hit_b ? b_view : rf_arr[gi]);
    assign stall_vec[gi] = (hit_a & a_pend_reg & ~fill_a) |
                           (hit_b & b_pend_reg & ~fill_b);
  end

  assign bus.rs1_fwd        = fwd_arr[0];
  assign bus.rs2_fwd        = fwd_arr[1];
  assign bus.load_use_stall = |stall_vec;
  assign bus.load_err       = load_err_reg;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed and random stimulus for operand_bypass_unit, checked against a
// write-history queue model with oldest-pending-first load return.
module tb_operand_bypass_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_bypass_if #(.XLEN(XLEN)) bus ();

  operand_bypass_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [XLEN-1:0] data;
    bit              pend;
  } slot_t;

  slot_t hist[$];     // index 0 = newest write, last = oldest kept
  bit    m_err;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    slot_t z;
    z.data = '0;
    z.pend = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_err = 1'b0;
  endfunction

  // Which history entry the current load return resolves (-1 when none).
  function automatic int fill_idx();
    if (bus.load_valid)
      for (int i = hist.size() - 1; i >= 0; i--)
        if (hist[i].pend) return i;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] exp_fwd(logic [1:0] sel, logic [XLEN-1:0] rf);
    int f;
    int i;
    f = fill_idx();
    if (sel == 2'd1 || sel == 2'd2) begin
      i = int'(sel) - 1;
      return (i == f) ? bus.load_data : hist[i].data;
    end
    return rf;
  endfunction

  function automatic bit exp_stall_one(logic [1:0] sel);
    int i;
    if (sel == 2'd1 || sel == 2'd2) begin
      i = int'(sel) - 1;
      return hist[i].pend && (i != fill_idx());
    end
    return 1'b0;
  endfunction

  function automatic void model_tick();
    int    f;
    slot_t s;
    f = fill_idx();
    if (f >= 0) begin
      hist[f].data = bus.load_data;
      hist[f].pend = 1'b0;
    end else if (bus.load_valid) begin
      m_err = 1'b1;
    end
    if (bus.res_valid && !bus.stall_in) begin
      s.data = bus.res_is_load ? '0 : bus.res_data;
      s.pend = bus.res_is_load;
      hist.push_front(s);
      void'(hist.pop_back());
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, "_rs1"}, bus.rs1_fwd, exp_fwd(bus.rs1_sel, bus.rf_rs1_data));
    chk({tag, "_rs2"}, bus.rs2_fwd, exp_fwd(bus.rs2_sel, bus.rf_rs2_data));
    chk({tag, "_stall"}, {31'd0, bus.load_use_stall},
        {31'd0, exp_stall_one(bus.rs1_sel) | exp_stall_one(bus.rs2_sel)});
    chk({tag, "_err"}, {31'd0, bus.load_err}, {31'd0, m_err});
  endtask

  // Inputs are already driven; check at negedge, then let the posedge land.
  task automatic cycle(string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    bus.res_valid   = 1'b0;
    bus.res_is_load = 1'b0;
    bus.res_data    = '0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.stall_in    = 1'b0;
  endtask

  task automatic commit(logic is_load, logic [XLEN-1:0] d);
    idle();
    bus.res_valid   = 1'b1;
    bus.res_is_load = is_load;
    bus.res_data    = d;
    cycle("commit");
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.rs1_sel     = 2'd0;
    bus.rs2_sel     = 2'd0;
    bus.rf_rs1_data = 32'h11;
    bus.rf_rs2_data = 32'h22;
    model_reset();
    #2;
    chk("t1_rs1_rf", bus.rs1_fwd, 32'h11);
    bus.rs1_sel = 2'd1;
    #1;
    chk("t1_rs1_slotA", bus.rs1_fwd, 32'h0);
    chk("t1_stall", {31'd0, bus.load_use_stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two ALU writes: A=9, B=5
    commit(1'b0, 32'd5);
    commit(1'b0, 32'd9);
    bus.rs1_sel = 2'd1;
    bus.rs2_sel = 2'd2;
    #1;
    chk("t2_rs1_A", bus.rs1_fwd, 32'd9);
    chk("t2_rs2_B", bus.rs2_fwd, 32'd5);
    bus.rs1_sel = 2'd3;
    #1;
    chk("t2_rs1_rf", bus.rs1_fwd, 32'h11);
    cycle("t2");

    // Single load: stall, then same-cycle bypass, then visible in A
    commit(1'b1, 32'hDEAD);
    bus.rs1_sel = 2'd1;
    bus.rs2_sel = 2'd0;
    #1;
    chk("t3_stall_pend", {31'd0, bus.load_use_stall}, 32'd1);
    cycle("t3a");
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hCAFE;
    #1;
    chk("t3_bypass", bus.rs1_fwd, 32'hCAFE);
    chk("t3_stall_fill", {31'd0, bus.load_use_stall}, 32'd0);
    cycle("t3b");
    idle();
    #1;
    chk("t3_A_after", bus.rs1_fwd, 32'hCAFE);
    cycle("t3c");

    // Two loads back-to-back; the first return resolves the older one (B)
    commit(1'b1, 32'h0);
    commit(1'b1, 32'h0);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'd7;
    cycle("t4_fill");
    idle();
    bus.rs1_sel = 2'd0;
    bus.rs2_sel = 2'd1;
    #1;
    chk("t4_stall_A", {31'd0, bus.load_use_stall}, 32'd1);
    bus.rs2_sel = 2'd2;
    #1;
    chk("t4_rs2_B", bus.rs2_fwd, 32'd7);
    chk("t4_nostall_B", {31'd0, bus.load_use_stall}, 32'd0);

    // ALU commit and fill of pending A in the same cycle
    bus.res_valid  = 1'b1;
    bus.res_data   = 32'd3;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'd8;
    cycle("t5");
    idle();
    bus.rs1_sel = 2'd1;
    bus.rs2_sel = 2'd2;
    #1;
    chk("t5_A", bus.rs1_fwd, 32'd3);
    chk("t5_B", bus.rs2_fwd, 32'd8);
    chk("t5_stall", {31'd0, bus.load_use_stall}, 32'd0);

    // Orphan load return sets a sticky error
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h55;
    cycle("t6_orphan");
    idle();
    chk("t6_err_set", {31'd0, bus.load_err}, 32'd1);
    cycle("t6_hold");
    chk("t6_err_sticky", {31'd0, bus.load_err}, 32'd1);

    // Frozen pipeline: res_valid ignored
    bus.stall_in  = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = 32'h99;
    cycle("t6_frozen");
    idle();
    #1;
    chk("t6_frozen_A", bus.rs1_fwd, 32'd3);
    chk("t6_frozen_B", bus.rs2_fwd, 32'd8);

    // Asynchronous reset mid-sequence clears immediately
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_A", bus.rs1_fwd, 32'h0);
    chk("t6_rst_B", bus.rs2_fwd, 32'h0);
    chk("t6_rst_err", {31'd0, bus.load_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      bus.rs1_sel     = 2'($urandom_range(0, 3));
      bus.rs2_sel     = 2'($urandom_range(0, 3));
      bus.rf_rs1_data = $urandom;
      bus.rf_rs2_data = $urandom;
      bus.stall_in    = ($urandom_range(0, 4) == 0);
      bus.res_valid   = !bus.stall_in && ($urandom_range(0, 1) == 1);
      bus.res_is_load = ($urandom_range(0, 2) == 0);
      bus.res_data    = $urandom;
      bus.load_valid  = ($urandom_range(0, 2) == 0);
      bus.load_data   = $urandom;
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
